// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  localparam logic [3:0] PAT_DEFAULT = 4'b1001;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter: increments on en, holds at all ones instead of wrapping.
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and match counter.
// Optional compare mask enabled by defining SEQ_DET_MASK_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEFAULT),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask,
`endif
  output logic             data_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int H_W    = PAT_W - 1;
  localparam int FILL_W = $clog2(PAT_W);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W out of supported range");
  end

  state_t            state_q, state_d;
  logic [H_W-1:0]    hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  window;
  logic              hit;
  logic              match_d;

  // Newest bit sits in the LSB, so the window lines up MSB-first with the pattern.
  assign window = {hist_q, data_in};

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask_q;
  assign hit = ((window ^ pat_q) & mask_q) == '0;
`else
  assign hit = (window == pat_q);
`endif

  // NOTE: every always_comb output gets a default first; a path that forgets to
  // assign would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (cfg_we) begin
      state_d = S_FILL;
      hist_d  = '0;
      fill_d  = '0;
    end else if (in_valid) begin
      case (state_q)
        S_FILL: begin
          hist_d = window[H_W-1:0];
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(PAT_W - 2)) state_d = S_ARMED;
        end
        S_ARMED: begin
          match_d = hit;
          if (hit && !overlap) begin
            state_d = S_FILL;
            hist_d  = '0;
            fill_d  = '0;
          end else begin
            hist_d = window[H_W-1:0];
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      hist_q   <= '0;
      fill_q   <= '0;
      pat_q    <= PAT_RST;
      data_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      data_out <= match_d;
      if (cfg_we) pat_q <= cfg_pattern;
    end
  end

`ifdef SEQ_DET_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mask_q <= '1;
    else if (cfg_we) mask_q <= cfg_mask;
  end
`endif

  assign armed = (state_q == S_ARMED);

  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (match_d),
    .cnt  (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; mask test runs when SEQ_DET_MASK_EN is defined.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pattern = 4'b1001;
  logic [3:0] cfg_mask = 4'b1111;
  logic       data_out;
  logic [7:0] match_cnt;
  logic       armed;

  logic       data2 = 1'b0;
  logic       valid2 = 1'b0;
  logic       overlap2 = 1'b1;
  logic       cfg_we2 = 1'b0;
  logic [3:0] cfg_pattern2 = 4'b1111;
  logic [3:0] cfg_mask2 = 4'b1111;
  logic       data_out2;
  logic [1:0] match_cnt2;
  logic       armed2;

  int checks = 0;
  int errors = 0;

  logic [15:0] stim16;
  logic [15:0] exp16;
  logic [6:0]  stim7;
  logic [6:0]  exp7;
  logic [5:0]  stim6;
  logic [5:0]  exp6;

  always #10 clk = ~clk;

  seq_detector_param #(
    .PAT_W  (4),
    .PAT_RST(4'b1001),
    .CNT_W  (8)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .overlap    (overlap),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask   (cfg_mask),
`endif
    .data_out   (data_out),
    .match_cnt  (match_cnt),
    .armed      (armed)
  );

  seq_detector_param #(
    .PAT_W  (4),
    .PAT_RST(4'b1111),
    .CNT_W  (2)
  ) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data2),
    .in_valid   (valid2),
    .overlap    (overlap2),
    .cfg_we     (cfg_we2),
    .cfg_pattern(cfg_pattern2),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask   (cfg_mask2),
`endif
    .data_out   (data_out2),
    .match_cnt  (match_cnt2),
    .armed      (armed2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic drive(input logic b, input logic v, input logic we);
    @(negedge clk);
    data_in  = b;
    in_valid = v;
    cfg_we   = we;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic b, input logic v);
    @(negedge clk);
    data2  = b;
    valid2 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    data_in  = 1'b0;
    valid2   = 1'b0;
    #2;
    check({tag, "_rst_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_rst_cnt"}, 32'(match_cnt), 32'd0);
    check({tag, "_rst_armed"}, 32'(armed), 32'd0);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    // Default pattern 1001, overlapping, 16-bit stream: pulses after bits 11 and 16.
    do_reset("t1");
    check("t1_rst_cnt2", 32'(match_cnt2), 32'd0);
    overlap = 1'b1;
    stim16  = 16'b1000_0101_0011_1001;
    exp16   = 16'b0000_0000_0010_0001;
    for (int i = 15; i >= 0; i--) begin
      drive(stim16[i], 1'b1, 1'b0);
      check($sformatf("t1_pulse_bit%0d", 16 - i), 32'(data_out), 32'(exp16[i]));
      if (i == 14 || i == 13)
        check($sformatf("t1_armed_bit%0d", 16 - i), 32'(armed), 32'(i == 13));
    end
    check("t1_cnt", 32'(match_cnt), 32'd2);
    drive(1'b1, 1'b0, 1'b0);
    check("t1_idle_data_out", 32'(data_out), 32'd0);

    // 1001001 overlapping: pulses after bits 4 and 7.
    do_reset("t2a");
    overlap = 1'b1;
    stim7   = 7'b1001001;
    exp7    = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      drive(stim7[i], 1'b1, 1'b0);
      check($sformatf("t2a_pulse_bit%0d", 7 - i), 32'(data_out), 32'(exp7[i]));
    end
    check("t2a_cnt", 32'(match_cnt), 32'd2);

    // Same stream non-overlapping: history cleared after bit 4, only one pulse.
    do_reset("t2b");
    overlap = 1'b0;
    exp7    = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      drive(stim7[i], 1'b1, 1'b0);
      check($sformatf("t2b_pulse_bit%0d", 7 - i), 32'(data_out), 32'(exp7[i]));
    end
    check("t2b_cnt", 32'(match_cnt), 32'd1);

    // Mid-stream load of 1010; the bit presented with cfg_we is dropped, count kept.
    overlap = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    cfg_pattern = 4'b1010;
    drive(1'b0, 1'b1, 1'b1);
    check("t3_load_armed", 32'(armed), 32'd0);
    check("t3_load_data_out", 32'(data_out), 32'd0);
    stim6 = 6'b101010;
    exp6  = 6'b000101;
    for (int i = 5; i >= 0; i--) begin
      drive(stim6[i], 1'b1, 1'b0);
      check($sformatf("t3_pulse_bit%0d", 6 - i), 32'(data_out), 32'(exp6[i]));
      if (i == 4 || i == 3)
        check($sformatf("t3_armed_bit%0d", 6 - i), 32'(armed), 32'(i == 3));
    end
    check("t3_cnt", 32'(match_cnt), 32'd3);

    // Second instance: 1111 with CNT_W=2; seven 1s give four back-to-back pulses.
    overlap2 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      drive2(1'b1, 1'b1);
      check($sformatf("t4_pulse_bit%0d", k), 32'(data_out2), 32'(k >= 4));
      check($sformatf("t4_cnt_bit%0d", k), 32'(match_cnt2), (k < 4) ? 32'd0 : (k == 4) ? 32'd1 : (k == 5) ? 32'd2 : 32'd3);
    end
    drive2(1'b1, 1'b0);
    check("t4_idle_data_out", 32'(data_out2), 32'd0);
    check("t4_cnt_sat", 32'(match_cnt2), 32'd3);

    // in_valid gaps: invalid cycles carry 1s that must be ignored.
    do_reset("t5");
    overlap = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      check($sformatf("t5_gap%0d_data_out", k), 32'(data_out), 32'd0);
    end
    check("t5_gap_armed", 32'(armed), 32'd0);
    drive(1'b0, 1'b1, 1'b0);
    check("t5_bit3_data_out", 32'(data_out), 32'd0);
    drive(1'b1, 1'b1, 1'b0);
    check("t5_bit4_data_out", 32'(data_out), 32'd1);
    check("t5_cnt", 32'(match_cnt), 32'd1);
    check("t5_armed", 32'(armed), 32'd1);

    // Asynchronous reset between clock edges clears outputs at once.
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_data_out", 32'(data_out), 32'd0);
    check("t5_async_cnt", 32'(match_cnt), 32'd0);
    check("t5_async_armed", 32'(armed), 32'd0);
    check("t5_async_cnt2", 32'(match_cnt2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SEQ_DET_MASK_EN
    // Mask 1001 makes the middle bits don't-care: 1111 matches pattern 1001.
    do_reset("t6");
    overlap     = 1'b1;
    cfg_pattern = 4'b1001;
    cfg_mask    = 4'b1001;
    drive(1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      check($sformatf("t6_pulse_bit%0d", k), 32'(data_out), 32'(k == 4));
    end
    check("t6_cnt", 32'(match_cnt), 32'd1);
    cfg_mask = 4'b1111;
`endif

    drive(1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
